// File: rtl/memory_matrix_pkg.sv
// Shared definitions for the Memory Matrix game blocks: FSM states, default sizes and width helpers.
package memory_matrix_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REVEAL = 3'd1,
        S_PLAY   = 3'd2,
        S_WIN    = 3'd3,
        S_LOSE   = 3'd4
    } state_t;

    localparam int N_TILES_DEF       = 8;
    localparam int TILE_IDX_W        = $clog2(N_TILES_DEF);
    localparam int REVEAL_CYCLES_DEF = 50_000_000;
    localparam int MAX_MISSES_DEF    = 3;

    // Down-counter width able to hold cycles-1, never narrower than one bit.
    function automatic int counter_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

    // Miss counter is at least two bits wide so small tolerances still read sensibly.
    function automatic int miss_width(input int max_misses);
        return ($clog2(max_misses + 1) < 2) ? 2 : $clog2(max_misses + 1);
    endfunction

endpackage

// File: rtl/reveal_timer.sv
// Loadable down-counter; done is high while the count sits at zero. Also used for display blink timing.
module reveal_timer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/match_checker.sv
// Memory Matrix round checker: reveal a latched board, take guesses, declare win/loss.
// Optional macro MISS_TOLERANCE_EN allows up to MAX_MISSES misses and adds the misses output.
module match_checker
    import memory_matrix_pkg::*;
#(
    parameter int N_TILES       = N_TILES_DEF,
    parameter int REVEAL_CYCLES = REVEAL_CYCLES_DEF,
    parameter int MAX_MISSES    = MAX_MISSES_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         board_valid,
    input  logic [N_TILES-1:0]           board,
    input  logic                         guess_valid,
    input  logic [$clog2(N_TILES)-1:0]   guess_idx,
    output logic [N_TILES-1:0]           display,
    output logic [N_TILES-1:0]           found,
    output logic [$clog2(N_TILES+1)-1:0] hits,
    output logic                         playing,
    output logic                         round_win,
`ifdef MISS_TOLERANCE_EN
    output logic [miss_width(MAX_MISSES)-1:0] misses,
`endif
    output logic                         round_lose
);

    localparam int CNT_W = counter_width(REVEAL_CYCLES);
    localparam int HIT_W = $clog2(N_TILES + 1);
`ifdef MISS_TOLERANCE_EN
    localparam int MISS_W = miss_width(MAX_MISSES);
`endif

    state_t             state;
    logic [N_TILES-1:0] board_q;
    logic [N_TILES-1:0] found_hit;
    logic               guess_in_range;
    logic               timer_done;

    assign found_hit      = found | (N_TILES'(1) << guess_idx);
    assign guess_in_range = (int'(guess_idx) < N_TILES);

    reveal_timer #(
        .WIDTH (CNT_W)
    ) u_reveal_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (board_valid),
        .load_value (CNT_W'(REVEAL_CYCLES - 1)),
        .en         (state == S_REVEAL),
        .done       (timer_done)
    );

    // Every output is assigned alongside the state transition that defines it, so all are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            board_q    <= '0;
            display    <= '0;
            found      <= '0;
            hits       <= '0;
            playing    <= 1'b0;
            round_win  <= 1'b0;
            round_lose <= 1'b0;
`ifdef MISS_TOLERANCE_EN
            misses     <= '0;
`endif
        end else if (board_valid) begin
            state      <= S_REVEAL;
            board_q    <= board;
            display    <= board;
            found      <= '0;
            hits       <= '0;
            playing    <= 1'b0;
            round_win  <= 1'b0;
            round_lose <= 1'b0;
`ifdef MISS_TOLERANCE_EN
            misses     <= '0;
`endif
        end else begin
            case (state)
                S_REVEAL: begin
                    if (timer_done) begin
                        state   <= S_PLAY;
                        display <= found;
                        playing <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (board_q == '0) begin
                        state     <= S_WIN;
                        display   <= board_q;
                        playing   <= 1'b0;
                        round_win <= 1'b1;
                    end else if (guess_valid && guess_in_range) begin
                        if (board_q[guess_idx]) begin
                            if (!found[guess_idx]) begin
                                found <= found_hit;
                                hits  <= hits + HIT_W'(1);
                                if (found_hit == board_q) begin
                                    state     <= S_WIN;
                                    display   <= board_q;
                                    playing   <= 1'b0;
                                    round_win <= 1'b1;
                                end else begin
                                    display <= found_hit;
                                end
                            end
                        end else begin
`ifdef MISS_TOLERANCE_EN
                            misses <= misses + MISS_W'(1);
                            if (misses + MISS_W'(1) == MISS_W'(MAX_MISSES)) begin
                                state      <= S_LOSE;
                                display    <= board_q;
                                playing    <= 1'b0;
                                round_lose <= 1'b1;
                            end
`else
                            state      <= S_LOSE;
                            display    <= board_q;
                            playing    <= 1'b0;
                            round_lose <= 1'b1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_checker.sv
// Self-checking bench for match_checker: directed table, corner sequences, and random play vs a round model.
module tb_match_checker;

    localparam int N   = 8;
    localparam int REV = 4;
`ifdef MISS_TOLERANCE_EN
    localparam int MISS_LIMIT = 3;
`else
    localparam int MISS_LIMIT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       board_valid;
    logic [7:0] board;
    logic       guess_valid;
    logic [2:0] guess_idx;
    logic [7:0] display;
    logic [7:0] found;
    logic [3:0] hits;
    logic       playing;
    logic       round_win;
    logic       round_lose;
`ifdef MISS_TOLERANCE_EN
    logic [1:0] misses;
`endif

    match_checker #(
        .N_TILES       (N),
        .REVEAL_CYCLES (REV),
        .MAX_MISSES    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .board_valid (board_valid),
        .board       (board),
        .guess_valid (guess_valid),
        .guess_idx   (guess_idx),
        .display     (display),
        .found       (found),
        .hits        (hits),
        .playing     (playing),
        .round_win   (round_win),
`ifdef MISS_TOLERANCE_EN
        .misses      (misses),
`endif
        .round_lose  (round_lose)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Round model: phase of the game, the board answer and the set of tiles found so far.
    localparam int P_IDLE = 0, P_SHOW = 1, P_GUESS = 2, P_WON = 3, P_LOST = 4;
    int         m_phase;
    int         m_show_left;
    int         m_miss_cnt;
    logic [7:0] m_board;
    logic [7:0] m_found;

    task automatic model_reset();
        m_phase = P_IDLE; m_show_left = 0; m_miss_cnt = 0; m_board = '0; m_found = '0;
    endtask

    task automatic model_step(input logic bv, input logic [7:0] b, input logic gv, input int gi);
        if (bv) begin
            m_board = b; m_found = '0; m_miss_cnt = 0; m_show_left = REV; m_phase = P_SHOW;
        end else if (m_phase == P_SHOW) begin
            m_show_left--;
            if (m_show_left == 0) m_phase = P_GUESS;
        end else if (m_phase == P_GUESS) begin
            if (m_board == 0) m_phase = P_WON;
            else if (gv && gi < N) begin
                if (m_board[gi]) begin
                    m_found[gi] = 1'b1;
                    if (m_found == m_board) m_phase = P_WON;
                end else begin
                    m_miss_cnt++;
                    if (m_miss_cnt >= MISS_LIMIT) m_phase = P_LOST;
                end
            end
        end
    endtask

    task automatic compare_model();
        logic [7:0] exp_disp;
        case (m_phase)
            P_SHOW, P_WON, P_LOST: exp_disp = m_board;
            P_GUESS:               exp_disp = m_found;
            default:               exp_disp = '0;
        endcase
        check("display", 32'(display), 32'(exp_disp));
        check("found", 32'(found), 32'(m_found));
        check("hits", 32'(hits), $countones(m_found));
        check("playing", 32'(playing), 32'(m_phase == P_GUESS));
        check("round_win", 32'(round_win), 32'(m_phase == P_WON));
        check("round_lose", 32'(round_lose), 32'(m_phase == P_LOST));
`ifdef MISS_TOLERANCE_EN
        check("misses", 32'(misses), 32'(m_miss_cnt));
`endif
    endtask

    // One clock: drive inputs, advance model at the edge, compare just after.
    task automatic cycle(input logic bv, input logic [7:0] b, input logic gv, input logic [2:0] gi);
        board_valid = bv; board = b; guess_valid = gv; guess_idx = gi;
        @(posedge clk);
        model_step(bv, b, gv, int'(gi));
        #1;
        compare_model();
        board_valid = 1'b0; guess_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, board, 1'b0, 3'd0);
    endtask

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       gv;
        logic [2:0] gi;
        logic [7:0] disp;
        logic [7:0] fnd;
        logic [3:0] hit;
        logic       play;
        logic       win;
        logic       lose;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 3'd0, 8'hA5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 3'd0, 8'hA5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'hA5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'hA5, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 3'd0, 8'h01, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 3'd2, 8'h05, 8'h05, 4'd2, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 3'd5, 8'h25, 8'h25, 4'd3, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 3'd7, 8'hA5, 8'hA5, 4'd4, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 3'd1, 8'hA5, 8'hA5, 4'd4, 1'b0, 1'b1, 1'b0};

        reset = 1'b0; board_valid = 1'b0; board = '0; guess_valid = 1'b0; guess_idx = '0;
        model_reset();
        #12;
        compare_model();
        reset = 1'b1;

        // Reset asserted mid-reveal clears everything without a clock edge.
        cycle(1'b1, 8'hA5, 1'b0, 3'd0);
        idle(1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("rst_display", 32'(display), 32'h0);
        check("rst_playing", 32'(playing), 32'h0);
        compare_model();
        #1 reset = 1'b1;

        // Full winning round with back-to-back guesses; the guess during reveal is ignored.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].bv, vecs[i].b, vecs[i].gv, vecs[i].gi);
            check($sformatf("vec%0d_display", i), 32'(display), 32'(vecs[i].disp));
            check($sformatf("vec%0d_found", i), 32'(found), 32'(vecs[i].fnd));
            check($sformatf("vec%0d_hits", i), 32'(hits), 32'(vecs[i].hit));
            check($sformatf("vec%0d_flags", i), {29'd0, playing, round_win, round_lose},
                  {29'd0, vecs[i].play, vecs[i].win, vecs[i].lose});
        end

        // Repeat guess is neither a hit nor a miss; a tile outside the board is a miss.
        cycle(1'b1, 8'hA5, 1'b0, 3'd0);
        idle(REV);
        cycle(1'b0, board, 1'b1, 3'd0);
        cycle(1'b0, board, 1'b1, 3'd0);
        check("repeat_hits", 32'(hits), 32'd1);
        cycle(1'b0, board, 1'b1, 3'd1);
`ifdef MISS_TOLERANCE_EN
        check("miss1_playing", 32'(playing), 32'd1);
        check("miss1_count", 32'(misses), 32'd1);
`else
        check("miss_lose", 32'(round_lose), 32'd1);
        check("miss_display", 32'(display), 32'hA5);
`endif

        // Empty board: one cycle in play, then an immediate win.
        cycle(1'b1, 8'h00, 1'b0, 3'd0);
        idle(REV);
        check("empty_playing", 32'(playing), 32'd1);
        idle(1);
        check("empty_win", 32'(round_win), 32'd1);

        // New board beats a simultaneous guess and aborts the round.
        cycle(1'b1, 8'hA5, 1'b0, 3'd0);
        idle(REV);
        cycle(1'b0, board, 1'b1, 3'd0);
        check("abort_pre_found", 32'(found), 32'h01);
        cycle(1'b1, 8'h0F, 1'b1, 3'd2);
        check("abort_found", 32'(found), 32'h00);
        check("abort_display", 32'(display), 32'h0F);
        check("abort_playing", 32'(playing), 32'd0);

`ifdef MISS_TOLERANCE_EN
        // Misses accumulate until the limit is reached.
        cycle(1'b1, 8'hA5, 1'b0, 3'd0);
        idle(REV);
        cycle(1'b0, board, 1'b1, 3'd1);
        cycle(1'b0, board, 1'b1, 3'd3);
        check("tol_misses2", 32'(misses), 32'd2);
        check("tol_playing", 32'(playing), 32'd1);
        cycle(1'b0, board, 1'b1, 3'd4);
        check("tol_lose", 32'(round_lose), 32'd1);
        check("tol_misses3", 32'(misses), 32'd3);
`endif

        // Random play against the model.
        for (int i = 0; i < 800; i++) begin
            logic       bv;
            logic [7:0] b;
            bv = ($urandom_range(0, 24) == 0);
            b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            cycle(bv, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
